// File: rtl/seg_mux_ctrl.sv
// seg_mux_ctrl: time-multiplexed seven-segment driver with
// frame-synchronous shadow capture, guard interval and LZ blanking.
module seg_mux_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD   = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    sh_hex_q, sh_hex_d;
  logic                    sh_lz_q, sh_lz_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;

  logic                    cap;
  logic                    guard;
  logic [3:0]              nib;
  logic                    dsel;
  logic                    blank;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   sel_n;

  function automatic logic [6:0] decode(input logic [3:0] n,
                                        input logic       hex);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    if (!hex && n > 4'h9) s = 7'h3F;
    return s;
  endfunction

  assign cap   = (cnt_q == '0) && (idx_q == '0);
  assign guard = (cnt_q < GUARD);

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX)
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    sh_dig_d = cap ? digits   : sh_dig_q;
    sh_dp_d  = cap ? dp_in    : sh_dp_q;
    sh_hex_d = cap ? hex_mode : sh_hex_q;
    sh_lz_d  = cap ? blank_lz : sh_lz_q;
    tick_d   = cap;
  end

  // Walk from the leftmost digit so zero_above covers i..NUM_DIGITS-1.
  always_comb begin
    nib        = 4'h0;
    dsel       = 1'b0;
    blank      = 1'b0;
    zero_above = 1'b1;
    sel_n      = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (sh_dig_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        nib      = sh_dig_q[4*i +: 4];
        dsel     = sh_dp_q[i];
        blank    = sh_lz_q && (i != 0) && zero_above;
        sel_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && !guard) begin
      if (!blank) begin
        an_d  = sel_n;
        seg_d = decode(nib, sh_hex_q);
        dp_d  = ~dsel;
      end else if (dsel) begin
        an_d = sel_n;
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_hex_q <= 1'b0;
      sh_lz_q  <= 1'b0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_hex_q <= sh_hex_d;
      sh_lz_q  <= sh_lz_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// tb_seg_mux_ctrl: scenario tasks plus randomized traffic
// checked against a cycle-position reference model.
module tb_seg_mux_ctrl;

  localparam int N = 4;
  localparam int D = 8;
  localparam int G = 2;
  localparam int F = N * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;
  int k = 0;

  logic [15:0] sh_dig = 16'h0;
  logic [3:0]  sh_dp = 4'h0;
  logic        sh_hex = 1'b0;
  logic        sh_lz = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_tick;
  logic [6:0]  tbl [16];

  seg_mux_ctrl #(
    .NUM_DIGITS  (N),
    .DIGIT_CYCLES(D),
    .GUARD_CYCLES(G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .digits    (digits),
    .dp_in     (dp_in),
    .hex_mode  (hex_mode),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // k = edges since reset release; slot/position follow by division.
  task automatic clk_step();
    int pos, slot;
    logic [3:0] nib;
    logic blank;
    @(posedge clk);
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    if (!rst_n) begin
      k = 0;
      sh_dig = 16'h0; sh_dp = 4'h0; sh_hex = 1'b0; sh_lz = 1'b0;
    end else begin
      pos  = k % D;
      slot = (k / D) % N;
      nib  = sh_dig[4*slot +: 4];
      blank = sh_lz && slot > 0 && ((sh_dig >> (4*slot)) == 16'h0);
      if (en && pos >= G && (!blank || sh_dp[slot])) begin
        e_an[slot] = 1'b0;
        e_dp = ~sh_dp[slot];
        if (!blank)
          e_seg = (!sh_hex && nib > 4'h9) ? 7'h3F : tbl[nib];
      end
      if (k % F == 0) begin
        e_tick = 1'b1;
        sh_dig = digits; sh_dp = dp_in;
        sh_hex = hex_mode; sh_lz = blank_lz;
      end
      k++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      clk_step();
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset c=%0d an=%h seg=%h dp=%b tick=%b required F/7f/1/0",
                 c, an, seg, dp, frame_tick);
      end
      checks++;
    end
  endtask

  task automatic test_bcd_frame();
    digits = 16'h1234; hex_mode = 1'b0; blank_lz = 1'b0;
    dp_in = 4'h0; en = 1'b1; rst_n = 1'b1;
    for (int c = 0; c < 3 * F; c++) begin
      clk_step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL bcd_frame k=%0d an=%h seg=%h dp=%b tick=%b expected %h/%h/%b/%b",
                 k, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if (c == 0) begin
        if (frame_tick !== 1'b1) begin
          errors++;
          $display("FAIL first_tick tick=%b required 1", frame_tick);
        end
        checks++;
      end
      if (c == 2 || c == D + 2 || c == F + 26 || c == 2 * F + 2) begin
        if ({an, seg} !== ((c == 2)      ? {4'hE, 7'h19} :
                           (c == D + 2)  ? {4'hD, 7'h30} :
                           (c == F + 26) ? {4'h7, 7'h79} :
                                           {4'hE, 7'h00})) begin
          errors++;
          $display("FAIL slot_literal c=%0d an=%h seg=%h", c, an, seg);
        end
        checks++;
      end
      if (c == F + 18) digits = 16'h5678;
    end
  endtask

  task automatic test_hex_bcd();
    while (k % F != 0) clk_step();
    digits = 16'h00A5; hex_mode = 1'b1;
    for (int c = 0; c < 2 * F; c++) begin
      clk_step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL hex_bcd k=%0d an=%h seg=%h dp=%b tick=%b expected %h/%h/%b/%b",
                 k, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if (c == D + 2 || c == F + D + 2) begin
        if (seg !== ((c == D + 2) ? 7'h08 : 7'h3F)) begin
          errors++;
          $display("FAIL nibble_a c=%0d seg=%h", c, seg);
        end
        checks++;
      end
      if (c == 0) hex_mode = 1'b0;
    end
  endtask

  task automatic test_blanking();
    int low2, saw3, other;
    low2 = 0; saw3 = 0; other = 0;
    while (k % F != 0) clk_step();
    digits = 16'h0070; dp_in = 4'b1000; blank_lz = 1'b1;
    for (int c = 0; c < 2 * F; c++) begin
      clk_step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL blanking k=%0d an=%h seg=%h dp=%b tick=%b expected %h/%h/%b/%b",
                 k, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if (c < F) begin
        if (an[2] == 1'b0) low2++;
        if (an == 4'h7 && seg == 7'h7F && dp == 1'b0) saw3++;
      end else if (c > F) begin
        if (an != 4'hF && !(an == 4'hE && seg == 7'h40)) other++;
      end
      if (c == 0) begin
        digits = 16'h0000; dp_in = 4'h0;
      end
    end
    if (low2 != 0 || saw3 != D - G || other != 0) begin
      errors++;
      $display("FAIL lz_summary an2_low=%0d dp_only=%0d stray=%0d required 0/%0d/0",
               low2, saw3, other, D - G);
    end
    checks++;
  endtask

  task automatic test_en_pulse();
    int offc;
    offc = 0;
    while (k % F != 0) clk_step();
    digits = 16'h1234; blank_lz = 1'b0; dp_in = 4'b0010;
    for (int c = 0; c <= F; c++) begin
      clk_step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL en_pulse k=%0d an=%h seg=%h dp=%b tick=%b expected %h/%h/%b/%b",
                 k, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if (c >= D + G && c < 2 * D && an == 4'hF) offc++;
      if (c == D + 3) en = 1'b0;
      if (c == D + 6) en = 1'b1;
    end
    if (offc != 3 || frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL en_window off=%0d tick=%b required 3/1", offc, frame_tick);
    end
    checks++;
  endtask

  task automatic test_reset_midframe();
    while (k % F != 0) clk_step();
    for (int c = 0; c < 2 * D + 5; c++) clk_step();
    rst_n = 1'b0;
    clk_step();
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset an=%h seg=%h dp=%b tick=%b required F/7f/1/0",
               an, seg, dp, frame_tick);
    end
    checks++;
    rst_n = 1'b1;
    for (int c = 0; c < F; c++) begin
      clk_step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL after_reset k=%0d an=%h seg=%h dp=%b tick=%b expected %h/%h/%b/%b",
                 k, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      if (c == 2) begin
        if ({an, frame_tick} !== {4'hE, 1'b0}) begin
          errors++;
          $display("FAIL restart_idx0 an=%h tick=%b required E/0", an, frame_tick);
        end
        checks++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    for (int c = 0; c < 600; c++) begin
      clk_step();
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL random k=%0d an=%h seg=%h dp=%b tick=%b expected %h/%h/%b/%b",
                 k, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      checks++;
      digits   = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_in    = 4'($urandom);
      hex_mode = 1'($urandom);
      blank_lz = 1'($urandom);
      en       = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 99) != 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    test_reset();
    test_bcd_frame();
    test_hex_bcd();
    test_blanking();
    test_en_pulse();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
